// File: rtl/nx_host_bridge.sv
// nx_host_bridge: byte-wide host link in front of the nexus top level.
// Ingress parses host header bytes into mesh words, the active level and
// counter-read requests. Egress frames mesh words and counter values back
// to the host as a header byte followed by an MSB-first body.
module nx_host_bridge #(
  parameter int unsigned STREAM_WIDTH  = 32,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               host_rx_data_i,
  input  logic                     host_rx_valid_i,
  output logic                     host_rx_ready_o,
  output logic [7:0]               host_tx_data_o,
  output logic                     host_tx_valid_o,
  input  logic                     host_tx_ready_i,
  output logic                     active_o,
  input  logic [COUNTER_WIDTH-1:0] counter_i,
  output logic [STREAM_WIDTH-1:0]  mesh_inbound_data_o,
  output logic                     mesh_inbound_valid_o,
  input  logic                     mesh_inbound_ready_i,
  input  logic [STREAM_WIDTH-1:0]  mesh_outbound_data_i,
  input  logic                     mesh_outbound_valid_i,
  output logic                     mesh_outbound_ready_o
);

  localparam int unsigned SB = STREAM_WIDTH / 8;
  localparam int unsigned CB = COUNTER_WIDTH / 8;
  localparam int unsigned MW = (STREAM_WIDTH > COUNTER_WIDTH) ? STREAM_WIDTH : COUNTER_WIDTH;
  localparam int unsigned MB = MW / 8;
  localparam int unsigned IW = $clog2(SB + 1);
  localparam int unsigned BW = $clog2(MB + 1);

  typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_SEND} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_BODY} tx_state_t;

  rx_state_t               r_rx_state;
  logic [IW-1:0]           r_rx_idx;
  logic [STREAM_WIDTH-1:0] r_rx_word;
  logic                    r_rx_valid;
  logic                    r_rx_ready;
  logic                    r_active;
  logic                    r_cnt_pend;

  tx_state_t               r_tx_state;
  logic [MW-1:0]           r_tx_shift;
  logic [BW-1:0]           r_tx_left;
  logic [7:0]              r_tx_data;
  logic                    r_tx_valid;
  logic                    r_out_ready;

  logic                    w_rx_fire;
  logic                    w_cnt_set;
  logic                    w_cnt_take;
  logic                    w_cnt_pend_nxt;
  logic                    w_out_fire;
  logic [MW-1:0]           w_tx_shift_nxt;

  assign w_rx_fire      = host_rx_valid_i & r_rx_ready;
  assign w_cnt_set      = w_rx_fire & (r_rx_state == RX_HDR) & (host_rx_data_i[7:6] == 2'b10);
  assign w_cnt_take     = (r_tx_state == TX_IDLE) & r_cnt_pend;
  // A new request in the same cycle as the egress capture keeps the flag set
  assign w_cnt_pend_nxt = w_cnt_set | (r_cnt_pend & ~w_cnt_take);
  assign w_out_fire     = mesh_outbound_valid_i & r_out_ready;
  assign w_tx_shift_nxt = r_tx_shift << 8;

  assign host_rx_ready_o       = r_rx_ready;
  assign mesh_inbound_valid_o  = r_rx_valid;
  assign mesh_inbound_data_o   = r_rx_word;
  assign active_o              = r_active;
  assign host_tx_valid_o       = r_tx_valid;
  assign host_tx_data_o        = r_tx_data;
  assign mesh_outbound_ready_o = r_out_ready;

  // Counter-read request flag shared between ingress and egress
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt_pend <= 1'b0;
    end else begin
      r_cnt_pend <= w_cnt_pend_nxt;
    end
  end

  // Ingress FSM: header decode, payload assembly, mesh inbound handoff
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_state <= RX_HDR;
      r_rx_idx   <= '0;
      r_rx_word  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ready <= 1'b1;
      r_active   <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_HDR: begin
          // Header acceptance is held off while a counter read is outstanding
          r_rx_ready <= ~w_cnt_pend_nxt;
          if (w_rx_fire) begin
            case (host_rx_data_i[7:6])
              2'b00: begin
                r_rx_state <= RX_DATA;
                r_rx_idx   <= '0;
                r_rx_ready <= 1'b1;
              end
              2'b01:   r_active <= host_rx_data_i[0];
              default: ;
            endcase
          end
        end
        RX_DATA: begin
          if (w_rx_fire) begin
            r_rx_word <= (r_rx_word << 8) | STREAM_WIDTH'(host_rx_data_i);
            r_rx_idx  <= r_rx_idx + IW'(1);
            if (r_rx_idx == IW'(SB - 1)) begin
              r_rx_state <= RX_SEND;
              r_rx_ready <= 1'b0;
              r_rx_valid <= 1'b1;
            end
          end
        end
        RX_SEND: begin
          if (mesh_inbound_ready_i) begin
            r_rx_state <= RX_HDR;
            r_rx_valid <= 1'b0;
            r_rx_ready <= ~w_cnt_pend_nxt;
          end
        end
        default: begin
          r_rx_state <= RX_HDR;
          r_rx_valid <= 1'b0;
          r_rx_ready <= ~w_cnt_pend_nxt;
        end
      endcase
    end
  end

  // Egress FSM: capture counter or mesh word, then send header and body
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_state  <= TX_IDLE;
      r_tx_shift  <= '0;
      r_tx_left   <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_out_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_out_ready <= ~w_cnt_pend_nxt;
          // Counter request wins over a concurrently offered mesh word
          if (r_cnt_pend) begin
            r_tx_shift  <= MW'(counter_i) << (MW - COUNTER_WIDTH);
            r_tx_left   <= BW'(CB);
            r_tx_data   <= 8'h80;
            r_tx_valid  <= 1'b1;
            r_tx_state  <= TX_HDR;
            r_out_ready <= 1'b0;
          end else if (w_out_fire) begin
            r_tx_shift  <= MW'(mesh_outbound_data_i) << (MW - STREAM_WIDTH);
            r_tx_left   <= BW'(SB);
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b1;
            r_tx_state  <= TX_HDR;
            r_out_ready <= 1'b0;
          end
        end
        TX_HDR: begin
          if (host_tx_ready_i) begin
            r_tx_state <= TX_BODY;
            r_tx_data  <= r_tx_shift[MW-1 -: 8];
          end
        end
        TX_BODY: begin
          if (host_tx_ready_i) begin
            if (r_tx_left == BW'(1)) begin
              r_tx_state  <= TX_IDLE;
              r_tx_valid  <= 1'b0;
              r_tx_data   <= '0;
              r_tx_left   <= '0;
              r_out_ready <= ~w_cnt_pend_nxt;
            end else begin
              r_tx_shift <= w_tx_shift_nxt;
              r_tx_left  <= r_tx_left - BW'(1);
              r_tx_data  <= w_tx_shift_nxt[MW-1 -: 8];
            end
          end
        end
        default: begin
          r_tx_state  <= TX_IDLE;
          r_tx_valid  <= 1'b0;
          r_out_ready <= ~w_cnt_pend_nxt;
        end
      endcase
    end
  end

endmodule

// File: doc/nx_host_bridge.md
Name: nx_host_bridge

Overview:
Host-side link controller sitting directly in front of the nexus top-level. Converts a byte-wide host stream into framed commands:
- Data words are assembled and pushed into the mesh inbound stream.
- The active_o control level is driven to nexus active_i.
- Cycle-counter reads are answered.
Mesh outbound words and counter responses are serialised back to the host as framed byte sequences.

Parameters:
STREAM_WIDTH, 32, mesh stream word width; multiple of 8, >= 8
COUNTER_WIDTH, 32, width of nexus cycle counter; multiple of 8, >= 8

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
host_rx_data_i  in  8  host-to-device byte
host_rx_valid_i  in  1  host byte valid
host_rx_ready_o  out  1  bridge accepts host byte
host_tx_data_o  out  8  device-to-host byte
host_tx_valid_o  out  1  device byte valid
host_tx_ready_i  in  1  host accepts byte
active_o  out  1  drives nexus active_i
counter_i  in  COUNTER_WIDTH  nexus counter_o
mesh_inbound_data_o  out  STREAM_WIDTH  word to nexus inbound_data_i
mesh_inbound_valid_o  out  1  to nexus inbound_valid_i
mesh_inbound_ready_i  in  1  from nexus inbound_ready_o
mesh_outbound_data_i  in  STREAM_WIDTH  from nexus outbound_data_o
mesh_outbound_valid_i  in  1  from nexus outbound_valid_o
mesh_outbound_ready_o  out  1  to nexus outbound_ready_i

Behaviour:
- Handshakes: a transfer occurs when valid && ready on the rising edge. Valid never depends combinationally on ready. Data is held stable while valid && !ready.
- Reset: all state is cleared asynchronously. Partial words, pending requests and in-flight transmissions are discarded.
- Reset values: active_o=0, mesh_inbound_valid_o=0, mesh_inbound_data_o=0, host_tx_valid_o=0, host_tx_data_o=0, mesh_outbound_ready_o=1, host_rx_ready_o=1.
- Host header byte, field hdr[7:6]:
  - 00 DATA: followed by STREAM_WIDTH/8 payload bytes, MSB first.
  - 01 ACTIVE: active_o <= hdr[0], registered on the header handshake and visible the next cycle.
  - 10 READ_CNT: sets cnt_pend.
  - 11 reserved: consumed and ignored.
  - hdr[5:0] is ignored except hdr[0] for ACTIVE.
- Ingress FSM states: RX_HDR, RX_DATA, RX_SEND.
  - RX_HDR: host_rx_ready_o = !cnt_pend. A READ_CNT header arriving while cnt_pend is set is therefore stalled. A DATA header moves to RX_DATA with byte index 0.
  - RX_DATA: host_rx_ready_o = 1. Each accepted byte is shifted in at the LSB (word <= {word[W-9:0], byte}). The last byte moves to RX_SEND.
  - RX_SEND: host_rx_ready_o = 0, mesh_inbound_valid_o = 1. On mesh_inbound_ready_i, return to RX_HDR. No bubble is required beyond one cycle.
- Egress FSM states: TX_IDLE, TX_HDR, TX_BODY.
  - TX_IDLE: mesh_outbound_ready_o = !cnt_pend.
    - If cnt_pend: capture counter_i into the shift register, header = 0x80, byte count = COUNTER_WIDTH/8, clear cnt_pend, go to TX_HDR.
    - Else if mesh_outbound_valid_i: capture the mesh word (handshake completes this cycle), header = 0x00, byte count = STREAM_WIDTH/8, go to TX_HDR.
    - A counter request always has priority over an outbound word presented in the same cycle.
  - TX_HDR: host_tx_valid_o = 1, data = header. On handshake go to TX_BODY.
  - TX_BODY: host_tx_data_o = shift-register MSB byte. On each handshake, shift left by 8 and decrement the count. The last byte returns to TX_IDLE.
  - mesh_outbound_ready_o = 0 in TX_HDR and TX_BODY.
- Latency:
  - Host last payload byte accepted at edge N: mesh_inbound_valid_o high in cycle N+1.
  - Egress capture at edge N: header valid in cycle N+1.
  - Counter value is sampled at the capture edge, not at the request.
- Simultaneous events:
  - READ_CNT accepted in the same cycle TX_IDLE clears cnt_pend: the set wins, and the flag stays 1.
  - Ingress and egress run independently; READ_CNT is the only coupling.

Test Plan:
1. Host sends 0x00,0xDE,0xAD,0xBE,0xEF with mesh_inbound_ready_i low for 5 cycles. Expected: mesh_inbound_valid_o=1 with data 0xDEADBEEF, stable throughout; host_rx_ready_o=0 until the mesh handshake, then 1.
2. Host sends 0x41, then 0x40 later. Expected: active_o rises 1 cycle after the first handshake and falls 1 cycle after the second. Host sends 0xC5: no change to any output.
3. counter_i=0x00000123, host sends 0x80. Expected: tx bytes 0x80,0x00,0x00,0x01,0x23. Sending 0x80 twice back-to-back stalls the second header while pending and produces two responses.
4. mesh_outbound_data_i=0xCAFEF00D valid, host_tx_ready_i toggling 1/0. Expected: tx 0x00,0xCA,0xFE,0xF0,0x0D; mesh_outbound_ready_o high for exactly one handshake cycle.
5. cnt_pend set and mesh_outbound_valid_i high in the same TX_IDLE cycle. Expected: counter frame (0x80…) is sent first, then the 0x00 word frame; no word is lost.
6. Assert rst_i after 2 of 4 payload bytes and during TX_BODY. Expected: all outputs return to reset values immediately. A subsequent full 0x00,0x11,0x22,0x33,0x44 frame yields exactly 0x11223344.
